// File: rtl/seg_scan_bcd.sv
// Binary-to-BCD converter (serial double-dabble, one bit per clock) feeding a
// time-multiplexed multi-digit display scanner with optional leading-zero blanking.
// Ports: clk, rst (sync, active-high), bin_in/load (value + 1-cycle request,
//   ignored while busy), busy, ovf (value saturated), dig (4'hF = blank), sel_n.
module seg_scan_bcd #(
  parameter int N_DIGITS = 4,
  parameter int BIN_W    = 14,
  parameter int SCAN_DIV = 50000,
  parameter int LZ_BLANK = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [BIN_W-1:0]    bin_in,
  input  logic                load,
  output logic                busy,
  output logic                ovf,
  output logic [3:0]          dig,
  output logic [N_DIGITS-1:0] sel_n
);

  localparam int BCD_W = 4 * N_DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int PRE_W = $clog2(SCAN_DIV);
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  function automatic longint pow10(input int n);
    longint p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  // Largest value the display can show; larger inputs are clamped to it so that
  // no BCD nibble can ever exceed 9.
  localparam longint          MAX_L = pow10(N_DIGITS) - 1;
  localparam logic [BIN_W-1:0] MAX_B = BIN_W'(MAX_L);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t             state, state_nxt;
  logic [BIN_W-1:0]   bin_sh;
  logic [BCD_W-1:0]   bcd, bcd_adj, disp;
  logic [CNT_W-1:0]   cnt;
  logic               ovf_pend;
  logic               sat;
  logic [PRE_W-1:0]   pre, pre_nxt;
  logic [IDX_W-1:0]   idx, idx_nxt;
  logic [3:0]         nib;
  logic               blank;

  assign busy = (state != IDLE);
  assign sat  = (64'(bin_in) > 64'(MAX_L));

  // ---------------- conversion FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load) state_nxt = CONV;
      CONV:    if (cnt == CNT_W'(BIN_W - 1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Add-3 correction applied to every nibble before the shift.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_sh   <= '0;
      bcd      <= '0;
      cnt      <= '0;
      ovf_pend <= 1'b0;
      ovf      <= 1'b0;
      disp     <= '0;
    end else begin
      case (state)
        IDLE: if (load) begin
          bin_sh   <= sat ? MAX_B : bin_in;
          ovf_pend <= sat;
          bcd      <= '0;
          cnt      <= '0;
        end
        CONV: begin
          bcd    <= {bcd_adj[BCD_W-2:0], bin_sh[BIN_W-1]};
          bin_sh <= bin_sh << 1;
          cnt    <= cnt + CNT_W'(1);
        end
        DONE: begin
          // Value and overflow flag become visible together.
          disp <= bcd;
          ovf  <= ovf_pend;
        end
        default: ;
      endcase
    end
  end

  // ---------------- digit scanner ----------------
  always_comb begin
    pre_nxt = pre + PRE_W'(1);
    idx_nxt = idx;
    if (pre == PRE_W'(SCAN_DIV - 1)) begin
      pre_nxt = '0;
      idx_nxt = (idx == IDX_W'(N_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
    end
  end

  // Select the nibble for the upcoming slot, and blank it when it and every
  // more-significant nibble are zero (digit 0 always shows).
  always_comb begin
    nib   = 4'h0;
    blank = (LZ_BLANK != 0) && (idx_nxt != '0);
    for (int i = 0; i < N_DIGITS; i++) begin
      if (IDX_W'(i) == idx_nxt) nib = disp[4*i +: 4];
      if ((i >= int'(idx_nxt)) && (disp[4*i +: 4] != 4'h0)) blank = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre   <= '0;
      idx   <= '0;
      sel_n <= ~N_DIGITS'(1);
      dig   <= 4'h0;
    end else begin
      pre   <= pre_nxt;
      idx   <= idx_nxt;
      sel_n <= ~(N_DIGITS'(1) << idx_nxt);
      dig   <= blank ? 4'hF : nib;
    end
  end

endmodule

// File: tb/tb_seg_scan_bcd.sv
// Testbench for seg_scan_bcd: directed scenarios plus random loads/resets,
// checked every cycle against an arithmetic model of the display.
// Ports of the DUT are all driven/observed here; no ports of its own.
module tb_seg_scan_bcd;

  localparam int N_DIGITS = 4;
  localparam int BIN_W    = 14;
  localparam int SCAN_DIV = 4;
  localparam int MAXV     = 9999;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [BIN_W-1:0]    bin_in = '0;
  logic                load = 1'b0;
  logic                busy, ovf;
  logic [3:0]          dig;
  logic [N_DIGITS-1:0] sel_n;

  int n_vec = 0;
  int n_err = 0;

  seg_scan_bcd #(
    .N_DIGITS(N_DIGITS), .BIN_W(BIN_W), .SCAN_DIV(SCAN_DIV), .LZ_BLANK(1)
  ) dut (
    .clk(clk), .rst(rst), .bin_in(bin_in), .load(load),
    .busy(busy), .ovf(ovf), .dig(dig), .sel_n(sel_n)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected code for digit position i of value v (leading zeros blanked).
  function automatic logic [3:0] exp_digit(input int v, input int i);
    int p;
    p = 1;
    for (int j = 0; j < i; j++) p = p * 10;
    if (i > 0 && v < p) return 4'hF;
    return 4'((v / p) % 10);
  endfunction

  // Reference model: a conversion accepted at an edge delivers its clamped value
  // BIN_W+1 edges later; busy lasts exactly that long. The scan position is a
  // pure function of edges since reset; the digit is drawn from the display
  // value held before the edge.
  bit   m_valid = 0;
  int   k = 0, m_cnt = 0, m_disp = 0, m_pend = 0, m_idx = 0;
  bit   m_ovf = 0, m_pend_ovf = 0;
  logic [3:0]          e_dig = '0;
  logic [N_DIGITS-1:0] e_sel = '1;

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        m_valid = 1; k = 0; m_cnt = 0; m_disp = 0; m_ovf = 0;
        e_sel = ~N_DIGITS'(1); e_dig = 4'h0;
      end else if (m_valid) begin
        k++;
        m_idx = (k / SCAN_DIV) % N_DIGITS;
        e_sel = ~(N_DIGITS'(1) << m_idx);
        e_dig = exp_digit(m_disp, m_idx);
        if (m_cnt > 0) begin
          if (m_cnt == 1) begin
            m_disp = m_pend;
            m_ovf  = m_pend_ovf;
          end
          m_cnt--;
        end else if (load) begin
          m_pend_ovf = (int'(bin_in) > MAXV);
          m_pend     = m_pend_ovf ? MAXV : int'(bin_in);
          m_cnt      = BIN_W + 1;
        end
      end
      @(negedge clk);
      if (m_valid) begin
        check("busy",  32'(busy),  32'(m_cnt > 0));
        check("ovf",   32'(ovf),   32'(m_ovf));
        check("sel_n", 32'(sel_n), 32'(e_sel));
        check("dig",   32'(dig),   32'(e_dig));
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input int v);
    @(negedge clk);
    bin_in = BIN_W'(v);
    load   = 1'b1;
    @(negedge clk);
    load   = 1'b0;
  endtask

  initial begin
    // Reset held for three cycles.
    rst = 1'b1;
    cycles(3);
    rst = 1'b0;
    check("rst_busy",  32'(busy),  32'd0);
    check("rst_ovf",   32'(ovf),   32'd0);
    check("rst_sel_n", 32'(sel_n), 32'b1110);
    check("rst_dig",   32'(dig),   32'd0);

    // Basic conversion and a few full scan rotations.
    do_load(1234);
    cycles(50);

    // Saturation, then a normal value clears the flag.
    do_load(12345);
    cycles(20);
    check("ovf_set", 32'(ovf), 32'd1);
    do_load(42);
    cycles(20);
    check("ovf_clr", 32'(ovf), 32'd0);

    // Leading-zero blanking and interior zeros.
    do_load(7);    cycles(36);
    do_load(0);    cycles(36);
    do_load(1000); cycles(36);

    // Second load during conversion is dropped.
    do_load(55);
    cycles(3);
    do_load(99);
    cycles(36);

    // Reset in the middle of a conversion.
    do_load(1234);
    cycles(7);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy",  32'(busy),  32'd0);
    check("abort_sel_n", 32'(sel_n), 32'b1110);
    check("abort_dig",   32'(dig),   32'd0);
    cycles(40);

    // Random traffic: loads (some while busy), occasional resets.
    for (int it = 0; it < 80; it++) begin
      if ($urandom_range(0, 11) == 0) begin
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end else begin
        do_load(($urandom_range(0, 7) == 0) ? int'($urandom_range(10000, 16383))
                                             : int'($urandom_range(0, 9999)));
      end
      for (int g = $urandom_range(0, 30); g > 0; g--) begin
        @(negedge clk);
        load   = ($urandom_range(0, 9) == 0);
        bin_in = BIN_W'($urandom_range(0, 16383));
      end
      @(negedge clk);
      load = 1'b0;
    end

    cycles(40);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
